beam_scan_ctrl: RTL and testbench



---
 rtl/beam_pkg.sv | 28 ++
 rtl/beam_scan_ctrl_if.sv | 35 +++
 rtl/beam_energy_acc.sv | 52 +++++
 rtl/beam_scan_ctrl.sv | 149 ++++++++++++++
 tb/tb_beam_scan_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/beam_pkg.sv
// Shared definitions for the beam scan controller: angle width, FSM state
// encoding and the helper functions that derive data-path widths.
package beam_pkg;

  localparam int ANGLE_W     = 7;
  localparam int LOAD_CYCLES = 4;

  // FSM state encoding, kept as plain constants for legacy tool flows
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_LOAD    = 3'd1;
  localparam state_t ST_SETTLE  = 3'd2;
  localparam state_t ST_DWELL   = 3'd3;
  localparam state_t ST_COMPARE = 3'd4;
  localparam state_t ST_NEXT    = 3'd5;
  localparam state_t ST_DONE    = 3'd6;

  // Offset-binary midpoint: the code that represents zero signal
  function automatic int midpoint(input int bit_width);
    return 1 << (bit_width - 1);
  endfunction

  // Accumulator width that cannot overflow over one full dwell
  function automatic int energy_width(input int bit_width, input int dwell_samples);
    return bit_width + $clog2(dwell_samples);
  endfunction

endpackage

// File: rtl/beam_scan_ctrl_if.sv
// Bundle of control, sample and result signals between the beam scan
// controller (slave side) and the surrounding system (master side).
interface beam_scan_ctrl_if
  import beam_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int ENERGY_W  = 16
);

  logic                       start;
  logic                       abort;
  logic                       sample_valid;
  logic [BIT_WIDTH-1:0]       beam_data;
  logic                       steer_en;
  logic signed [ANGLE_W-1:0]  steer_hori;
  logic signed [ANGLE_W-1:0]  steer_vert;
  logic                       busy;
  logic                       done;
  logic signed [ANGLE_W-1:0]  best_hori;
  logic signed [ANGLE_W-1:0]  best_vert;
  logic [ENERGY_W-1:0]        best_energy;

  modport master (
    output start, abort, sample_valid, beam_data,
    input  steer_en, steer_hori, steer_vert, busy, done,
    input  best_hori, best_vert, best_energy
  );

  modport slave (
    input  start, abort, sample_valid, beam_data,
    output steer_en, steer_hori, steer_vert, busy, done,
    output best_hori, best_vert, best_energy
  );

endinterface

// File: rtl/beam_energy_acc.sv
// Dwell energy accumulator: sums |sample - midpoint| over a fixed number of
// valid samples and flags the cycle that carries the final sample.
module beam_energy_acc
  import beam_pkg::*;
#(
  parameter int BIT_WIDTH     = 8,
  parameter int DWELL_SAMPLES = 256,
  parameter int ENERGY_W      = energy_width(BIT_WIDTH, DWELL_SAMPLES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 enable,
  input  logic                 sample_valid,
  input  logic [BIT_WIDTH-1:0] beam_data,
  output logic [ENERGY_W-1:0]  energy,
  output logic                 dwell_done
);

  localparam int CNT_W = $clog2(DWELL_SAMPLES + 1);
  localparam logic [BIT_WIDTH-1:0] MID       = BIT_WIDTH'(midpoint(BIT_WIDTH));
  localparam logic [CNT_W-1:0]     LAST_SAMP = CNT_W'(DWELL_SAMPLES - 1);

  logic [BIT_WIDTH-1:0] abs_dev;
  logic [CNT_W-1:0]     sample_cnt;
  logic                 take;

  assign take       = enable && sample_valid;
  assign dwell_done = take && (sample_cnt == LAST_SAMP);

  // Magnitude of the sample's deviation from the offset-binary zero point
  always_comb begin
    abs_dev = '0;
    if (beam_data >= MID) abs_dev = beam_data - MID;
    else                  abs_dev = MID - beam_data;
  end

  // Running sum and sample count, both restarted before each dwell
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      energy     <= '0;
      sample_cnt <= '0;
    end else if (clear) begin
      energy     <= '0;
      sample_cnt <= '0;
    end else if (take) begin
      energy     <= energy + ENERGY_W'(abs_dev);
      sample_cnt <= sample_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/beam_scan_ctrl.sv
// Beam scan controller: steps the beamformer over a square angle grid
// (vertical outer, horizontal inner), measures dwell energy at each point
// and reports the angle with the strictly largest energy.
module beam_scan_ctrl
  import beam_pkg::*;
#(
  parameter int BIT_WIDTH     = 8,
  parameter int ANGLE_LIM     = 27,
  parameter int ANGLE_STEP    = 9,
  parameter int SETTLE_CYCLES = 16,
  parameter int DWELL_SAMPLES = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  beam_scan_ctrl_if.slave  bus
);

  localparam int ENERGY_W = energy_width(BIT_WIDTH, DWELL_SAMPLES);
  localparam int CNT_MAX  = (SETTLE_CYCLES > LOAD_CYCLES) ? SETTLE_CYCLES : LOAD_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] LOAD_LAST   = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  localparam logic signed [ANGLE_W-1:0] LIM_POS = ANGLE_W'(ANGLE_LIM);
  localparam logic signed [ANGLE_W-1:0] LIM_NEG = ANGLE_W'(-ANGLE_LIM);
  localparam logic signed [ANGLE_W-1:0] STEP    = ANGLE_W'(ANGLE_STEP);

  state_t                    state;
  state_t                    next_state;
  logic [CNT_W-1:0]          phase_cnt;
  logic [ENERGY_W-1:0]       acc_energy;
  logic                      dwell_done;
  logic [ENERGY_W-1:0]       wb_energy;
  logic signed [ANGLE_W-1:0] wb_hori;
  logic signed [ANGLE_W-1:0] wb_vert;
  logic                      hori_at_lim;
  logic                      vert_at_lim;

  assign hori_at_lim = (bus.steer_hori == LIM_POS);
  assign vert_at_lim = (bus.steer_vert == LIM_POS);

  beam_energy_acc #(
    .BIT_WIDTH     (BIT_WIDTH),
    .DWELL_SAMPLES (DWELL_SAMPLES),
    .ENERGY_W      (ENERGY_W)
  ) u_energy_acc (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (state == ST_SETTLE),
    .enable       (state == ST_DWELL),
    .sample_valid (bus.sample_valid),
    .beam_data    (bus.beam_data),
    .energy       (acc_energy),
    .dwell_done   (dwell_done)
  );

  // Next-state selection; abort overrides everything, including start in IDLE
  always_comb begin
    next_state = state;
    if (bus.abort) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (bus.start) next_state = ST_LOAD;
        ST_LOAD:    if (phase_cnt == LOAD_LAST) next_state = ST_SETTLE;
        ST_SETTLE:  if (phase_cnt == SETTLE_LAST) next_state = ST_DWELL;
        ST_DWELL:   if (dwell_done) next_state = ST_COMPARE;
        ST_COMPARE: next_state = ST_NEXT;
        ST_NEXT:    next_state = (hori_at_lim && vert_at_lim) ? ST_DONE : ST_LOAD;
        ST_DONE:    next_state = ST_IDLE;
        default:    next_state = ST_IDLE;
      endcase
    end
  end

  // State register and the shared LOAD/SETTLE phase counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      phase_cnt <= '0;
    end else begin
      state <= next_state;
      if (next_state != state)
        phase_cnt <= '0;
      else if (state == ST_LOAD || state == ST_SETTLE)
        phase_cnt <= phase_cnt + CNT_W'(1);
    end
  end

  // Steering angles and the working best point for the scan in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.steer_hori <= '0;
      bus.steer_vert <= '0;
      wb_energy      <= '0;
      wb_hori        <= '0;
      wb_vert        <= '0;
    end else begin
      if (state == ST_IDLE && next_state == ST_LOAD) begin
        bus.steer_hori <= LIM_NEG;
        bus.steer_vert <= LIM_NEG;
        wb_energy      <= '0;
        wb_hori        <= LIM_NEG;
        wb_vert        <= LIM_NEG;
      end
      if (state == ST_COMPARE && acc_energy > wb_energy) begin
        wb_energy <= acc_energy;
        wb_hori   <= bus.steer_hori;
        wb_vert   <= bus.steer_vert;
      end
      if (state == ST_NEXT && next_state == ST_LOAD) begin
        if (hori_at_lim) begin
          bus.steer_hori <= LIM_NEG;
          bus.steer_vert <= bus.steer_vert + STEP;
        end else begin
          bus.steer_hori <= bus.steer_hori + STEP;
        end
      end
    end
  end

  // Registered status outputs, derived from the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.steer_en <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      bus.steer_en <= (next_state == ST_LOAD);
      bus.busy     <= (next_state != ST_IDLE);
      bus.done     <= (state == ST_DONE) && !bus.abort;
    end
  end

  // Published result, refreshed only when a scan completes without abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.best_hori   <= '0;
      bus.best_vert   <= '0;
      bus.best_energy <= '0;
    end else if (state == ST_DONE && !bus.abort) begin
      bus.best_hori   <= wb_hori;
      bus.best_vert   <= wb_vert;
      bus.best_energy <= wb_energy;
    end
  end

endmodule

// File: tb/tb_beam_scan_ctrl.sv
// Self-checking bench for beam_scan_ctrl: full-scan table with a peak point
// per row, plus hand-written abort, start-while-busy, toggling-valid and
// asynchronous reset sequences.
module tb_beam_scan_ctrl;
  import beam_pkg::*;

  localparam int BW         = 8;
  localparam int EW         = energy_width(8, 256);
  localparam int POINT_LEN  = 4 + 16 + 256 + 2;
  localparam int SCAN_LEN   = 49 * POINT_LEN + 1;
  localparam int SCAN_LIMIT = 20000;

  typedef struct {
    logic [BW-1:0] base_data;
    logic          use_peak;
    int            peak_hori;
    int            peak_vert;
    logic [BW-1:0] peak_data;
    int            exp_hori;
    int            exp_vert;
    int            exp_energy;
  } vec_t;

  logic clk;
  logic rst_n;
  int   assert_count;
  int   fail_count;
  vec_t vecs[4];

  beam_scan_ctrl_if #(.BIT_WIDTH(BW), .ENERGY_W(EW)) bus ();

  beam_scan_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [BW-1:0] pickData(input vec_t v);
    if (v.use_peak && int'(bus.steer_hori) == v.peak_hori && int'(bus.steer_vert) == v.peak_vert)
      return v.peak_data;
    return v.base_data;
  endfunction

  task automatic stepCycles(input int n, input logic [BW-1:0] data, inout bit done_seen);
    for (int i = 0; i < n; i++) begin
      bus.beam_data = data;
      @(negedge clk);
      if (bus.done) done_seen = 1'b1;
    end
  endtask

  task automatic pulseStart();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input int row);
    int cycles;
    bit seen;
    bus.beam_data = pickData(v);
    pulseStart();
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < SCAN_LIMIT) begin
      bus.beam_data = pickData(v);
      @(negedge clk);
      cycles++;
      if (bus.done) seen = 1'b1;
    end
    $display("[TB] row %0d: done after %0d cycles", row, cycles);
    checkOutput("done_seen", int'(seen), 1);
    checkOutput("done_latency", cycles, SCAN_LEN);
    checkOutput("best_hori", int'(bus.best_hori), v.exp_hori);
    checkOutput("best_vert", int'(bus.best_vert), v.exp_vert);
    checkOutput("best_energy", int'(bus.best_energy), v.exp_energy);
    checkOutput("busy_at_done", int'(bus.busy), 0);
    @(negedge clk);
    checkOutput("done_one_cycle", int'(bus.done), 0);
  endtask

  // Main test sequence
  initial begin
    bit done_seen;
    int k;
    int idx;

    assert_count = 0;
    fail_count   = 0;

    vecs[0] = '{8'd128, 1'b0, 0,   0,   8'd128, -27, -27, 0};
    vecs[1] = '{8'd128, 1'b1, 9,   -18, 8'd200, 9,   -18, 18432};
    vecs[2] = '{8'd138, 1'b0, 0,   0,   8'd138, -27, -27, 2560};
    vecs[3] = '{8'd128, 1'b1, 27,  27,  8'd0,   27,  27,  32768};

    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.sample_valid = 1'b1;
    bus.beam_data    = 8'd128;

    #23;
    checkOutput("rst_steer_en", int'(bus.steer_en), 0);
    checkOutput("rst_steer_hori", int'(bus.steer_hori), 0);
    checkOutput("rst_steer_vert", int'(bus.steer_vert), 0);
    checkOutput("rst_busy", int'(bus.busy), 0);
    checkOutput("rst_done", int'(bus.done), 0);
    checkOutput("rst_best_hori", int'(bus.best_hori), 0);
    checkOutput("rst_best_vert", int'(bus.best_vert), 0);
    checkOutput("rst_best_energy", int'(bus.best_energy), 0);

    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 4; r++) applyStimulus(vecs[r], r);

    // abort and start together in IDLE: abort wins
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checkOutput("abort_wins_busy", int'(bus.busy), 0);
    checkOutput("abort_wins_steer_en", int'(bus.steer_en), 0);

    // LOAD length, start while busy, abort in DWELL of point 5
    done_seen = 1'b0;
    pulseStart();
    checkOutput("load_busy", int'(bus.busy), 1);
    checkOutput("load_hori", int'(bus.steer_hori), -27);
    checkOutput("load_vert", int'(bus.steer_vert), -27);
    k = 0;
    while (bus.steer_en && k < 10) begin
      stepCycles(1, 8'd128, done_seen);
      k++;
    end
    checkOutput("load_len", k, 4);
    stepCycles(296, 8'd128, done_seen);
    pulseStart();
    stepCycles(9, 8'd128, done_seen);
    checkOutput("busy_start_ignored_hori", int'(bus.steer_hori), -18);
    checkOutput("busy_start_ignored_busy", int'(bus.busy), 1);
    stepCycles(872, 8'd128, done_seen);
    checkOutput("p5_hori", int'(bus.steer_hori), 9);
    bus.abort = 1'b1;
    stepCycles(1, 8'd128, done_seen);
    bus.abort = 1'b0;
    checkOutput("abort_busy", int'(bus.busy), 0);
    checkOutput("abort_steer_en", int'(bus.steer_en), 0);
    checkOutput("abort_best_hori", int'(bus.best_hori), 27);
    checkOutput("abort_best_vert", int'(bus.best_vert), 27);
    checkOutput("abort_best_energy", int'(bus.best_energy), 32768);
    stepCycles(300, 8'd128, done_seen);
    checkOutput("abort_no_done", int'(done_seen), 0);
    checkOutput("abort_stays_idle", int'(bus.busy), 0);

    // sample_valid toggling: dwell of 256 samples takes 512 cycles
    done_seen = 1'b0;
    pulseStart();
    stepCycles(4, 8'd128, done_seen);
    checkOutput("toggle_settle_entry", int'(bus.steer_en), 0);
    idx = 0;
    while (idx < 2000 && !(idx > 0 && bus.steer_en)) begin
      bus.sample_valid = (idx >= 16) && (((idx - 16) % 2) == 1);
      @(negedge clk);
      idx++;
    end
    bus.sample_valid = 1'b1;
    checkOutput("toggle_point_len", idx, 16 + 512 + 2);
    checkOutput("toggle_next_hori", int'(bus.steer_hori), -18);
    bus.abort = 1'b1;
    stepCycles(1, 8'd128, done_seen);
    bus.abort = 1'b0;
    checkOutput("toggle_abort_busy", int'(bus.busy), 0);

    // asynchronous reset in the middle of SETTLE
    pulseStart();
    stepCycles(10, 8'd128, done_seen);
    checkOutput("pre_rst_busy", int'(bus.busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_steer_en", int'(bus.steer_en), 0);
    checkOutput("mid_rst_steer_hori", int'(bus.steer_hori), 0);
    checkOutput("mid_rst_steer_vert", int'(bus.steer_vert), 0);
    checkOutput("mid_rst_busy", int'(bus.busy), 0);
    checkOutput("mid_rst_done", int'(bus.done), 0);
    checkOutput("mid_rst_best_hori", int'(bus.best_hori), 0);
    checkOutput("mid_rst_best_vert", int'(bus.best_vert), 0);
    checkOutput("mid_rst_best_energy", int'(bus.best_energy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
